// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine
// Stride-1 2-D convolution with implicit zero padding, per-filter bias, optional
// ReLU and output saturation. One multiply-accumulate per cycle; activations,
// weights and biases come from synchronous-read ports (data one cycle after the
// strobe); results leave through a valid/ready port in (f, i, j) order.
module conv2d_stream_engine #(
    parameter int IN_CH  = 16,
    parameter int OUT_CH = 32,
    parameter int IMG_H  = 14,
    parameter int IMG_W  = 14,
    parameter int K      = 3,
    parameter int PAD    = 1,
    parameter int DATA_W = 32,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 48,
    parameter int RELU   = 1,
    localparam int OH    = IMG_H + 2*PAD - K + 1,
    localparam int OW    = IMG_W + 2*PAD - K + 1,
    localparam int IA_N  = IN_CH*IMG_H*IMG_W,
    localparam int WA_N  = OUT_CH*IN_CH*K*K,
    localparam int OA_N  = OUT_CH*OH*OW,
    localparam int IA_W  = (IA_N > 1) ? $clog2(IA_N) : 1,
    localparam int WA_W  = (WA_N > 1) ? $clog2(WA_N) : 1,
    localparam int BA_W  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
    localparam int OA_W  = (OA_N > 1) ? $clog2(OA_N) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              sat_flag,
    output logic              in_rd_en,
    output logic [IA_W-1:0]   in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              wt_rd_en,
    output logic [WA_W-1:0]   wt_addr,
    input  logic [WGT_W-1:0]  wt_data,
    output logic              b_rd_en,
    output logic [BA_W-1:0]   b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OA_W-1:0]   out_addr,
    output logic [DATA_W-1:0] out_data
);

    localparam int N = IN_CH*K*K;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t state;

    // Pixel position (f, i, j), tap position (c, m, n) and tap ordinal
    logic [31:0] f_idx, i_idx, j_idx;
    logic [31:0] c_idx, m_idx, n_idx, tap;
    logic signed [ACC_W-1:0] acc;
    // High when the data arriving this cycle belongs to an in-image tap
    logic prev_in;
    logic sat_pend;

    logic signed [ACC_W-1:0] in_ext, wt_ext, bias_ext, prod, acc_sum;
    logic signed [ACC_W-1:0] sat_max, sat_min;
    logic [DATA_W-1:0]       res;
    logic                    clip;

    logic [31:0]        iss_c, iss_m, iss_n;
    logic signed [31:0] row, col;
    logic               iss_in;
    logic [IA_W-1:0]    iss_in_addr;
    logic [WA_W-1:0]    iss_wt_addr;

    logic [31:0] nx_f, nx_i, nx_j;
    logic        last_pix;

    // Sign-extend operands and form the accumulator update for the returning tap
    always_comb begin
        in_ext   = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
        wt_ext   = {{(ACC_W-WGT_W){wt_data[WGT_W-1]}}, wt_data};
        bias_ext = {{(ACC_W-DATA_W){b_data[DATA_W-1]}}, b_data};
        prod     = prev_in ? in_ext * wt_ext : '0;
        acc_sum  = acc + prod;
    end

    // ReLU and saturation of the final accumulator value
    always_comb begin
        sat_max = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        sat_min = ~sat_max;
        res     = acc_sum[DATA_W-1:0];
        clip    = 1'b0;
        if (RELU != 0 && acc_sum[ACC_W-1]) begin
            res = '0;
        end else if (acc_sum > sat_max) begin
            res  = sat_max[DATA_W-1:0];
            clip = 1'b1;
        end else if (acc_sum < sat_min) begin
            res  = sat_min[DATA_W-1:0];
            clip = 1'b1;
        end
    end

    // Next tap to issue (tap 0 from BIAS, successor of the current tap in MAC)
    always_comb begin
        iss_c = '0;
        iss_m = '0;
        iss_n = '0;
        if (state == S_MAC) begin
            iss_c = c_idx;
            iss_m = m_idx;
            iss_n = n_idx + 1;
            if (n_idx == K-1) begin
                iss_n = '0;
                iss_m = m_idx + 1;
                if (m_idx == K-1) begin
                    iss_m = '0;
                    iss_c = c_idx + 1;
                end
            end
        end
        row         = signed'(i_idx) + signed'(iss_m) - PAD;
        col         = signed'(j_idx) + signed'(iss_n) - PAD;
        iss_in      = (row >= 0) && (row < IMG_H) && (col >= 0) && (col < IMG_W);
        iss_in_addr = IA_W'(signed'(iss_c)*IMG_H*IMG_W + row*IMG_W + col);
        iss_wt_addr = WA_W'(((signed'(f_idx)*IN_CH + signed'(iss_c))*K
                             + signed'(iss_m))*K + signed'(iss_n));
    end

    // Next output pixel in j-fastest, then i, then f order
    always_comb begin
        nx_f = f_idx;
        nx_i = i_idx;
        nx_j = j_idx + 1;
        if (j_idx == OW-1) begin
            nx_j = '0;
            nx_i = i_idx + 1;
            if (i_idx == OH-1) begin
                nx_i = '0;
                nx_f = f_idx + 1;
            end
        end
        last_pix = (f_idx == OUT_CH-1) && (i_idx == OH-1) && (j_idx == OW-1);
    end

    // Control FSM with registered strobes, addresses and result port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            f_idx     <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            c_idx     <= '0;
            m_idx     <= '0;
            n_idx     <= '0;
            tap       <= '0;
            acc       <= '0;
            prev_in   <= 1'b0;
            sat_pend  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sat_flag  <= 1'b0;
            in_rd_en  <= 1'b0;
            in_addr   <= '0;
            wt_rd_en  <= 1'b0;
            wt_addr   <= '0;
            b_rd_en   <= 1'b0;
            b_addr    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            prev_in <= in_rd_en;
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= S_BIAS;
                        busy     <= 1'b1;
                        sat_flag <= 1'b0;
                        f_idx    <= '0;
                        i_idx    <= '0;
                        j_idx    <= '0;
                        b_rd_en  <= 1'b1;
                        b_addr   <= '0;
                    end
                end
                S_BIAS: begin
                    state    <= S_MAC;
                    b_rd_en  <= 1'b0;
                    c_idx    <= '0;
                    m_idx    <= '0;
                    n_idx    <= '0;
                    tap      <= '0;
                    wt_rd_en <= 1'b1;
                    wt_addr  <= iss_wt_addr;
                    in_rd_en <= iss_in;
                    in_addr  <= iss_in_addr;
                end
                S_MAC: begin
                    // Bias arrives in the first MAC cycle; later cycles add the previous tap
                    acc <= (tap == 0) ? bias_ext : acc_sum;
                    if (tap == N-1) begin
                        state    <= S_DRAIN;
                        wt_rd_en <= 1'b0;
                        in_rd_en <= 1'b0;
                    end else begin
                        tap      <= tap + 1;
                        c_idx    <= iss_c;
                        m_idx    <= iss_m;
                        n_idx    <= iss_n;
                        wt_addr  <= iss_wt_addr;
                        in_rd_en <= iss_in;
                        in_addr  <= iss_in_addr;
                    end
                end
                S_DRAIN: begin
                    state     <= S_WRITE;
                    acc       <= acc_sum;
                    out_valid <= 1'b1;
                    out_data  <= res;
                    out_addr  <= OA_W'(signed'(f_idx)*OH*OW + signed'(i_idx)*OW
                                       + signed'(j_idx));
                    sat_pend  <= clip;
                end
                S_WRITE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (sat_pend) begin
                            sat_flag <= 1'b1;
                        end
                        if (last_pix) begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state   <= S_BIAS;
                            f_idx   <= nx_f;
                            i_idx   <= nx_i;
                            j_idx   <= nx_j;
                            b_rd_en <= 1'b1;
                            b_addr  <= BA_W'(nx_f);
                        end
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed bench for conv2d_stream_engine: a single-channel 3x3 instance (RELU=0)
// and a two-channel, two-filter 3x3 instance (RELU=1), each with synchronous
// read memories that return junk when not strobed.
module tb_conv2d_stream_engine;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    // ---------------- instance A: 1 in-ch, 1 filter, 3x3, RELU=0 ----------------
    logic        a_start, a_busy, a_done, a_sat_flag;
    logic        a_in_rd_en, a_wt_rd_en, a_b_rd_en, a_out_valid, a_out_ready;
    logic [3:0]  a_in_addr, a_wt_addr, a_out_addr;
    logic [0:0]  a_b_addr;
    logic [31:0] a_in_data, a_b_data, a_out_data;
    logic [7:0]  a_wt_data;
    logic [31:0] a_in_mem [9];
    logic [7:0]  a_wt_mem [9];
    logic [31:0] a_b_val;

    conv2d_stream_engine #(
        .IN_CH(1), .OUT_CH(1), .IMG_H(3), .IMG_W(3), .K(3), .PAD(1),
        .DATA_W(32), .WGT_W(8), .ACC_W(48), .RELU(0)
    ) dut_a (
        .clk(clk), .reset(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
        .sat_flag(a_sat_flag), .in_rd_en(a_in_rd_en), .in_addr(a_in_addr),
        .in_data(a_in_data), .wt_rd_en(a_wt_rd_en), .wt_addr(a_wt_addr),
        .wt_data(a_wt_data), .b_rd_en(a_b_rd_en), .b_addr(a_b_addr), .b_data(a_b_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_addr(a_out_addr),
        .out_data(a_out_data)
    );

    // ---------------- instance B: 2 in-ch, 2 filters, 3x3, RELU=1 ----------------
    logic        b_start, b_busy, b_done, b_sat_flag;
    logic        b_in_rd_en, b_wt_rd_en, b_b_rd_en, b_out_valid, b_out_ready;
    logic [4:0]  b_in_addr, b_out_addr;
    logic [5:0]  b_wt_addr;
    logic [0:0]  b_b_addr;
    logic [31:0] b_in_data, b_b_data, b_out_data;
    logic [7:0]  b_wt_data;
    logic [31:0] b_in_mem [18];
    logic [7:0]  b_wt_mem [36];
    logic [31:0] b_b_mem [2];

    conv2d_stream_engine #(
        .IN_CH(2), .OUT_CH(2), .IMG_H(3), .IMG_W(3), .K(3), .PAD(1),
        .DATA_W(32), .WGT_W(8), .ACC_W(48), .RELU(1)
    ) dut_b (
        .clk(clk), .reset(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
        .sat_flag(b_sat_flag), .in_rd_en(b_in_rd_en), .in_addr(b_in_addr),
        .in_data(b_in_data), .wt_rd_en(b_wt_rd_en), .wt_addr(b_wt_addr),
        .wt_data(b_wt_data), .b_rd_en(b_b_rd_en), .b_addr(b_b_addr), .b_data(b_b_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_addr(b_out_addr),
        .out_data(b_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read memories; unstrobed reads return junk
    always @(posedge clk) begin
        a_in_data <= a_in_rd_en ? a_in_mem[a_in_addr] : 32'hDEAD_BEEF;
        a_wt_data <= a_wt_rd_en ? a_wt_mem[a_wt_addr] : 8'h5A;
        a_b_data  <= a_b_rd_en  ? a_b_val             : 32'h1234_5678;
        b_in_data <= b_in_rd_en ? b_in_mem[b_in_addr] : 32'hDEAD_BEEF;
        b_wt_data <= b_wt_rd_en ? b_wt_mem[b_wt_addr] : 8'h5A;
        b_b_data  <= b_b_rd_en  ? b_b_mem[b_b_addr]   : 32'h1234_5678;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run one pass on instance A from a negedge; optional 5-cycle stall on one
    // pixel and optional early return after a given number of accepted pixels.
    task automatic run_a(input string tag, input logic [31:0] exp [9],
                         input int stall_pix, input int abort_pix, input logic exp_sat);
        int cyc, last, pix, sc;
        logic [31:0] hd;
        logic [3:0]  ha;
        pix = 0; sc = 0; last = 0;
        hd = '0; ha = '0;
        a_out_ready = 1'b1;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        cyc = 1;
        chk({tag, " start busy/sat"}, 32'({a_busy, a_sat_flag}), 32'h2);
        while (pix < 9 && cyc < 400) begin
            if (a_out_valid) begin
                if (pix == stall_pix && sc < 5) begin
                    if (sc == 0) begin
                        hd = a_out_data;
                        ha = a_out_addr;
                    end else begin
                        chk({tag, " stall data"}, a_out_data, hd);
                        chk({tag, " stall addr"}, 32'(a_out_addr), 32'(ha));
                    end
                    a_out_ready = 1'b0;
                    sc++;
                end else begin
                    a_out_ready = 1'b1;
                    chk({tag, " data"}, a_out_data, exp[pix]);
                    chk({tag, " addr"}, 32'(a_out_addr), 32'(pix));
                    chk({tag, " interval"}, 32'(cyc - last),
                        32'((pix == stall_pix) ? 17 : 12));
                    last = cyc;
                    pix++;
                    if (pix == abort_pix) return;
                end
            end
            if (pix < 9) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, " pixel count"}, 32'(pix), 32'd9);
        @(negedge clk);
        chk({tag, " done/busy"}, 32'({a_done, a_busy}), 32'h2);
        @(negedge clk);
        chk({tag, " done cleared"}, 32'({a_done, a_busy}), 32'h0);
        chk({tag, " sat_flag"}, 32'(a_sat_flag), 32'(exp_sat));
    endtask

    task automatic run_b(input logic [31:0] exp [18]);
        int cyc, last, pix;
        pix = 0; last = 0;
        b_out_ready = 1'b1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        cyc = 1;
        while (pix < 18 && cyc < 800) begin
            if (b_out_valid) begin
                chk("B data", b_out_data, exp[pix]);
                chk("B addr", 32'(b_out_addr), 32'(pix));
                chk("B interval", 32'(cyc - last), 32'd21);
                last = cyc;
                pix++;
            end
            if (pix < 18) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("B pixel count", 32'(pix), 32'd18);
        @(negedge clk);
        chk("B done/busy", 32'({b_done, b_busy}), 32'h2);
        @(negedge clk);
        chk("B done cleared", 32'({b_done, b_busy}), 32'h0);
    endtask

    logic [31:0] e9  [9];
    logic [31:0] e18 [18];

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0;
        a_start = 1'b0; b_start = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            a_in_mem[k] = 32'd1;
            a_wt_mem[k] = 8'd1;
        end
        a_b_val = 32'd0;
        for (int k = 0; k < 9; k++) begin
            b_in_mem[k]     = 32'd1;
            b_in_mem[9 + k] = 32'd2;
        end
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < 9; k++)
                    b_wt_mem[(f*2 + c)*9 + k] = (f == 1 && c == 1) ? 8'hFF : 8'h01;
        b_b_mem[0] = -32'sd5;
        b_b_mem[1] = 32'd5;

        repeat (3) @(negedge clk);
        chk("reset ctrl A", 32'({a_busy, a_done, a_sat_flag, a_in_rd_en, a_wt_rd_en,
                                 a_b_rd_en, a_out_valid}), 32'h0);
        chk("reset data A", a_out_data, 32'h0);
        chk("reset addr A", 32'(a_out_addr), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // All ones, zero bias: corners 4, edges 6, centre 9
        e9 = '{4, 6, 4, 6, 9, 6, 4, 6, 4};
        run_a("T1", e9, -1, -1, 1'b0);

        // Bias -20 without ReLU
        a_b_val = -32'sd20;
        e9 = '{-16, -14, -16, -14, -11, -14, -16, -14, -16};
        run_a("T2", e9, -1, -1, 1'b0);

        // Positive and negative saturation
        a_b_val = 32'd0;
        for (int k = 0; k < 9; k++) begin
            a_in_mem[k] = 32'h7FFF_FFFF;
            a_wt_mem[k] = 8'd127;
        end
        for (int k = 0; k < 9; k++) e9[k] = 32'h7FFF_FFFF;
        run_a("T3pos", e9, -1, -1, 1'b1);
        for (int k = 0; k < 9; k++) a_in_mem[k] = 32'h8000_0000;
        for (int k = 0; k < 9; k++) e9[k] = 32'h8000_0000;
        run_a("T3neg", e9, -1, -1, 1'b1);

        // Distinct weights 1..9, unit inputs, stall on pixel 2
        for (int k = 0; k < 9; k++) begin
            a_in_mem[k] = 32'd1;
            a_wt_mem[k] = 8'(k + 1);
        end
        e9 = '{28, 39, 24, 33, 45, 27, 16, 21, 12};
        run_a("T4", e9, 2, -1, 1'b0);

        // Distinct inputs 1..9, unit weights
        for (int k = 0; k < 9; k++) begin
            a_in_mem[k] = 32'(k + 1);
            a_wt_mem[k] = 8'd1;
        end
        e9 = '{12, 21, 16, 27, 45, 33, 24, 39, 28};
        run_a("T5", e9, -1, -1, 1'b0);

        // Asynchronous reset mid-pass, then a complete pass from address 0
        run_a("T6a", e9, -1, 4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("T6 async ctrl", 32'({a_busy, a_done, a_sat_flag, a_in_rd_en, a_wt_rd_en,
                                  a_b_rd_en, a_out_valid}), 32'h0);
        chk("T6 async data", a_out_data, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("T6 held ctrl", 32'({a_busy, a_out_valid, a_in_rd_en}), 32'h0);
        chk("T6 held addr", 32'(a_out_addr), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        run_a("T6b", e9, -1, -1, 1'b0);

        // Two channels, two filters, ReLU on
        e18 = '{7, 13, 7, 13, 22, 13, 7, 13, 7,
                1, 0, 1, 0, 0, 0, 1, 0, 1};
        run_b(e18);
        chk("B sat_flag", 32'(b_sat_flag), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
